// File: rtl/inst_pkg.sv
// Shared definitions for the instruction encoder: format codes, opcode[6:2]
// class constants and the immediate range checker.
package inst_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // opcode[6:2] classes
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // True when imm is representable in the immediate field of format f.
  // Sign-extension ranges are checked as "all upper bits equal".
  function automatic logic imm_ok(input fmt_e f, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (f)
      FMT_I, FMT_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      FMT_J:        ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      FMT_U:        ok = ~(|imm[11:0]);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding encoder results.
// Ports: clk, rst_n (async, active low); push_i/data_i write side;
// pop_i/valid_o/data_o read side (data_o is zero when empty);
// full_o reflects registered occupancy only.
module enc_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e           occ_q, occ_d;
  logic [W-1:0]   mem_q [2];
  logic           wr_q, rd_q;
  logic           do_push, do_pop;

  assign do_push = push_i && (occ_q != OCC_FULL);
  assign do_pop  = pop_i  && (occ_q != OCC_EMPTY);

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (do_push) occ_d = OCC_ONE;
      OCC_ONE: begin
        if (do_push && !do_pop)      occ_d = OCC_FULL;
        else if (!do_push && do_pop) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (do_pop) occ_d = OCC_ONE;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= OCC_EMPTY;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      occ_q <= occ_d;
      wr_q  <= wr_q ^ do_push;
      rd_q  <= rd_q ^ do_pop;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o = (occ_q != OCC_EMPTY);
  assign full_o  = (occ_q == OCC_FULL);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs register/immediate fields by format,
// flags unencodable requests, buffers results in a 2-entry FIFO.
// Ports: clk, rst_n (async, active low); in_* request with valid/ready;
// out_* result with valid/ready (out_err marks an error entry, inst=0);
// enc_cnt/err_cnt saturating counts of accepted/errored requests.
module inst_encoder
  import inst_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  logic        init_q;
  logic [15:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic        fifo_full;
  logic        accept;
  logic [31:0] inst_raw;
  logic        class_ok, fmt_ok, err;
  logic [4:0]  opc_class;
  logic [32:0] fifo_out;

  assign opc_class = in_opcode[6:2];

  always_comb begin
    inst_raw = '0;
    class_ok = 1'b0;
    fmt_ok   = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_R: begin
        class_ok = (opc_class == OPC_OP);
        inst_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        class_ok = (opc_class == OPC_OPIMM) || (opc_class == OPC_LOAD) ||
                   (opc_class == OPC_JALR);
        inst_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: begin
        class_ok = (opc_class == OPC_STORE);
        inst_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        class_ok = (opc_class == OPC_BRANCH);
        inst_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
      FMT_U: begin
        class_ok = (opc_class == OPC_AUIPC) || (opc_class == OPC_LUI);
        inst_raw = {in_imm[31:12], in_rd, in_opcode};
      end
      FMT_J: begin
        class_ok = (opc_class == OPC_JAL);
        inst_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  assign err = !fmt_ok || !class_ok || (in_opcode[1:0] != 2'b11) ||
               !imm_ok(fmt_e'(in_fmt), in_imm);

  // init_q holds in_ready low until the first edge after reset release
  assign in_ready = init_q && !fifo_full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept && (enc_cnt_q != '1))        enc_cnt_d = enc_cnt_q + 16'd1;
    if (accept && err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      init_q    <= 1'b1;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  enc_fifo2 #(.W(33)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (err ? {1'b1, 32'h0} : {1'b0, inst_raw}),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .data_o  (fifo_out)
  );

  assign out_err  = fifo_out[32];
  assign out_inst = fifo_out[31:0];
  assign enc_cnt  = enc_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_inst;
  logic [15:0] enc_cnt, err_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_cnt   (enc_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Offer the current request until accepted (bounded), return at edge+1.
  task automatic send(input string tag);
    int unsigned n;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst, input logic err);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #2;
    chk("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Directed encodes, out_ready=1
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    send("I"); expect_out("I", 32'hFFF00093, 1'b0);
    chk("I_enc_cnt", {16'd0, enc_cnt}, 32'd1);
    set_req(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send("S"); expect_out("S", 32'h0020A423, 1'b0);
    set_req(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send("U"); expect_out("U", 32'h123452B7, 1'b0);
    set_req(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
    send("J"); expect_out("J", 32'h001000EF, 1'b0);
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    send("Bok"); expect_out("Bok", 32'h00208463, 1'b0);
    set_req(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF);
    send("R"); expect_out("R", 32'h402081B3, 1'b0);
    chk("ok_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Error cases
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    send("B4096"); expect_out("B4096", 32'h0, 1'b1);
    chk("B4096_err_cnt", {16'd0, err_cnt}, 32'd1);
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send("B3"); expect_out("B3", 32'h0, 1'b1);
    chk("B3_err_cnt", {16'd0, err_cnt}, 32'd2);
    set_req(3'd2, 7'b0010011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    send("SxOPIMM"); expect_out("SxOPIMM", 32'h0, 1'b1);
    set_req(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send("fmt6"); expect_out("fmt6", 32'h0, 1'b1);
    set_req(3'd1, 7'b0010010, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send("op_lo"); expect_out("op_lo", 32'h0, 1'b1);
    chk("err_err_cnt", {16'd0, err_cnt}, 32'd5);
    chk("err_enc_cnt", {16'd0, enc_cnt}, 32'd11);
    @(posedge clk); #1;
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: three requests with out_ready=0
    out_ready = 1'b0;
    set_req(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp1_inst", out_inst, 32'h00500113);
    chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
    set_req(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    @(posedge clk); #1;
    chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2_head", out_inst, 32'h00500113);
    set_req(3'd1, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    @(posedge clk); #1;
    chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3_head", out_inst, 32'h00500113);
    chk("bp3_enc_cnt", {16'd0, enc_cnt}, 32'd13);
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_out("bp_pop1", 32'h00600193, 1'b0);
    chk("bp_pop1_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;           // push C and pop B together
    in_valid = 1'b0;
    expect_out("bp_pushpop", 32'h00700213, 1'b0);
    chk("bp_pushpop_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_enc_cnt", {16'd0, enc_cnt}, 32'd14);
    @(posedge clk); #1;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Reset with two entries queued
    out_ready = 1'b0;
    set_req(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
